// File: rtl/adder_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_mon_pkg
// Description : Shared types and constants for the adder result monitor.
//               Holds the monitor state encoding, the upper bound on the
//               adder pipeline latency and the default widths used by the
//               top level.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_mon_pkg;

    // Deepest adder pipeline the monitor can track.
    localparam int LATENCY_MAX     = 16;

    // Default configuration of the monitor.
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_LATENCY = 1;
    localparam int DEFAULT_CNT_W   = 32;

    // Drain counter must reach LATENCY_MAX-1; one spare bit keeps the
    // increment from ever wrapping inside the legal range.
    localparam int DRAIN_CNT_W     = $clog2(LATENCY_MAX) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

endpackage : adder_mon_pkg
`default_nettype wire

// File: rtl/adder_mon_delay.sv
`default_nettype none
// ============================================================================
// Module      : adder_mon_delay
// Description : LATENCY-deep {valid, data} shift line. Every stage advances
//               on every rising clock edge; the reset clears only the valid
//               bits, the data bits are don't-care while invalid.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in  1      clock, rising edge
//   rst_n      in  1      asynchronous active-low reset (clears valid bits)
//   in_valid   in  1      valid bit loaded into stage 0
//   in_data    in  WIDTH  data loaded into stage 0
//   out_valid  out 1      valid bit of the last stage
//   out_data   out WIDTH  data of the last stage
// ============================================================================
module adder_mon_delay
    import adder_mon_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic [LATENCY-1:0]            r_valid;
    logic [LATENCY-1:0][WIDTH-1:0] r_data;

    generate
        if (LATENCY == 1) begin : g_single
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                end else begin
                    r_valid <= in_valid;
                end
            end

            always_ff @(posedge clk) begin
                r_data <= in_data;
            end
        end else begin : g_multi
            // Stage 0 sits at bit 0; the oldest entry is at LATENCY-1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= '0;
                end else begin
                    r_valid <= {r_valid[LATENCY-2:0], in_valid};
                end
            end

            always_ff @(posedge clk) begin
                r_data <= {r_data[LATENCY-2:0], in_data};
            end
        end
    endgenerate

    assign out_valid = r_valid[LATENCY-1];
    assign out_data  = r_data[LATENCY-1];

endmodule : adder_mon_delay
`default_nettype wire

// File: rtl/adder_monitor.sv
`default_nettype none
// ============================================================================
// Module      : adder_monitor
// Description : Result-side checker for the adder harness. Computes the
//               expected sum of each applied operand pair, delays it by the
//               adder latency, compares it with the adder result and keeps
//               pass/fail status plus statistic counters.
// Revision    : 1.0 - initial release
//
// Optional feature macro: ADDER_MON_FIRST_ERR_EN
//   defined   : first_*_o capture the first mismatch after reset and hold it
//   undefined : first_*_o are tied to zero, no capture registers exist
//
// Ports:
//   clk_i        in  1      clock, rising edge
//   reset_i      in  1      asynchronous active-low reset
//   valid_i      in  1      operands applied to the adder this cycle
//   a_i, b_i     in  WIDTH  operands as driven to the adder
//   res_i        in  WIDTH  adder result
//   done_i       in  1      stimulus exhausted (first high cycle counts)
//   checked_o    out CNT_W  number of results compared (wraps)
//   err_cnt_o    out CNT_W  number of mismatches (saturates)
//   busy_o       out 1      monitor in RUN or DRAIN
//   pass_o       out 1      sticky: finished with zero mismatches
//   fail_o       out 1      sticky: finished with at least one mismatch
//   first_idx_o  out CNT_W  checked_o value at the first mismatch
//   first_exp_o  out WIDTH  expected value at the first mismatch
//   first_got_o  out WIDTH  res_i at the first mismatch
// ============================================================================
module adder_monitor
    import adder_mon_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int LATENCY = DEFAULT_LATENCY,   // legal range 1..LATENCY_MAX
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] res_i,
    input  logic             done_i,
    output logic [CNT_W-1:0] checked_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] first_idx_o,
    output logic [WIDTH-1:0] first_exp_o,
    output logic [WIDTH-1:0] first_got_o
);

    localparam logic [CNT_W-1:0]       c_cnt_one   = CNT_W'(1);
    localparam logic [DRAIN_CNT_W-1:0] c_drain_one = DRAIN_CNT_W'(1);
    localparam logic [DRAIN_CNT_W-1:0] c_drain_last = DRAIN_CNT_W'(LATENCY - 1);

    mon_state_t             r_state;
    mon_state_t             w_next_state;
    logic [DRAIN_CNT_W-1:0] r_drain_cnt;

    logic                   w_accept;
    logic                   w_busy;
    logic [WIDTH-1:0]       w_sum;
    logic                   w_strobe;
    logic [WIDTH-1:0]       w_exp;
    logic                   w_mismatch;

    logic [CNT_W-1:0]       r_checked;
    logic [CNT_W-1:0]       r_err_cnt;
    logic                   r_pass;
    logic                   r_fail;

    // ------------------------------------------------------------------------
    // Expected value: the carry is dropped because the adder result is only
    // WIDTH bits wide.
    // ------------------------------------------------------------------------
    assign w_sum = a_i + b_i;

    adder_mon_delay #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk_i),
        .rst_n     (reset_i),
        .in_valid  (w_accept),
        .in_data   (w_sum),
        .out_valid (w_strobe),
        .out_data  (w_exp)
    );

    assign w_mismatch = w_strobe && (res_i != w_exp);

    // ------------------------------------------------------------------------
    // FSM: state register (with the drain cycle counter)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            // Counter is zero on entry to DRAIN and counts drain cycles.
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + c_drain_one;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                // done with nothing applied still finishes (zero-check pass).
                if (done_i) begin
                    w_next_state = ST_DRAIN;
                end else if (valid_i) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (done_i) begin
                    w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // LATENCY drain cycles flush the last operand to its compare.
                if (r_drain_cnt == c_drain_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_DONE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE:  w_accept = valid_i;
            ST_RUN: begin
                w_busy   = 1'b1;
                w_accept = valid_i;
            end
            ST_DRAIN: w_busy   = 1'b1;
            default: begin
                w_busy   = 1'b0;
                w_accept = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Statistic counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_checked <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_strobe) begin
                r_checked <= r_checked + c_cnt_one;
            end
            if (w_mismatch && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + c_cnt_one;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Verdict: taken on the first cycle spent in DONE, by which point the
    // last compare has already landed in r_err_cnt.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if ((r_state == ST_DONE) && !r_pass && !r_fail) begin
            if (r_err_cnt == '0) begin
                r_pass <= 1'b1;
            end else begin
                r_fail <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // First-mismatch capture
    // ------------------------------------------------------------------------
`ifdef ADDER_MON_FIRST_ERR_EN
    logic             r_first_seen;
    logic [CNT_W-1:0] r_first_idx;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_got;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_first_seen <= 1'b0;
            r_first_idx  <= '0;
            r_first_exp  <= '0;
            r_first_got  <= '0;
        end else if (w_mismatch && !r_first_seen) begin
            r_first_seen <= 1'b1;
            r_first_idx  <= r_checked;   // count before this compare
            r_first_exp  <= w_exp;
            r_first_got  <= res_i;
        end
    end

    assign first_idx_o = r_first_idx;
    assign first_exp_o = r_first_exp;
    assign first_got_o = r_first_got;
`else
    assign first_idx_o = '0;
    assign first_exp_o = '0;
    assign first_got_o = '0;
`endif

    assign checked_o = r_checked;
    assign err_cnt_o = r_err_cnt;
    assign busy_o    = w_busy;
    assign pass_o    = r_pass;
    assign fail_o    = r_fail;

endmodule : adder_monitor
`default_nettype wire

// File: doc/adder_monitor.md
# adder_monitor

Result-side checker for the adder test harness. It consumes the same operand stream the stimulus driver applies to the adder and the adder's `res` output. It computes the expected sum, delays it by the adder's pipeline latency, compares every result, and reports pass/fail with counters for the Verilator DPI testbench to read at end of run.

## Interface
Parameters:
- `WIDTH`, 8: operand and result width.
- `LATENCY`, 1: cycles from operand sample to valid `res`; legal range 1..16.
- `CNT_W`, 32: width of the statistic counters.

Ports:
- `clk_i` in 1: single clock; all logic on rising edge.
- `reset_i` in 1: asynchronous, active-low reset.
- `valid_i` in 1: `a_i`/`b_i` are being applied to the adder this cycle.
- `a_i` in WIDTH: operand A, as driven to the adder.
- `b_i` in WIDTH: operand B, as driven to the adder.
- `res_i` in WIDTH: adder result.
- `done_i` in 1: stimulus exhausted; pulse or level; first high cycle counts.
- `checked_o` out CNT_W: number of results compared.
- `err_cnt_o` out CNT_W: number of mismatches; saturates at all-ones.
- `busy_o` out 1: high in RUN or DRAIN.
- `pass_o` out 1: sticky; DONE reached with `err_cnt_o == 0`.
- `fail_o` out 1: sticky; DONE reached with `err_cnt_o != 0`.
- `first_idx_o` out CNT_W: `checked_o` value at the first mismatch.
- `first_exp_o` out WIDTH: expected value at the first mismatch.
- `first_got_o` out WIDTH: `res_i` at the first mismatch.

## Operation
- Expected value: `(a_i + b_i) mod 2^WIDTH`. The carry is discarded, so `res` width equals operand width.
- Delay line: `LATENCY` stages of {valid, expected}. Stage 0 loads on every edge, with `valid_i` gating the valid bit. The last stage's valid bit is the compare strobe.
- Compare: on a strobe edge, compare `res_i` with the last-stage expected value.
  - `checked_o` increments on every strobe.
  - `err_cnt_o` increments on each mismatch, saturating.
- State machine:
  - IDLE → RUN on the first `valid_i`.
  - RUN → DRAIN on `done_i`.
  - DRAIN: counts `LATENCY` cycles, then → DONE.
  - DONE: terminal until reset. Sets exactly one of `pass_o`/`fail_o`.
  - `done_i` in IDLE goes → DRAIN directly; this yields a zero-check pass.
- The delay line keeps shifting in every state. Strobes arriving in DRAIN are checked. `valid_i` in DRAIN/DONE is ignored: stage 0 loads invalid.
- Reset (any time, including mid-RUN): all outputs 0, delay line invalid, state IDLE. A reset pulse fully discards any in-flight results.

## Timing
- Operands sampled at edge N are compared against `res_i` sampled at edge N+LATENCY.
- Counters update at the compare edge and are visible after it.
- `pass_o`/`fail_o` rise at edge D+LATENCY+1, where D is the edge that samples `done_i`.
- Simultaneous `valid_i` and `done_i` in RUN: that operand is captured and checked; the state moves to DRAIN.
- Back-to-back `valid_i` every cycle is supported, with no bubbles required.

## Configuration
- `ADDER_MON_FIRST_ERR_EN` defined:
  - `first_*_o` latch on the first mismatch after reset and hold until reset.
  - Later mismatches do not overwrite them.
- Undefined: `first_*_o` are tied to 0 and their registers are not built.
- Counters and pass/fail are unaffected either way.

## Structure
- `adder_mon_pkg`: state enum typedef (IDLE, RUN, DRAIN, DONE), `LATENCY_MAX = 16`, default width constants.
- Sub-module `adder_mon_delay`: parameterised {valid, data} shift line, `LATENCY` deep, with asynchronous active-low reset clearing the valid bits.
- Top: FSM, comparator, counters, first-error capture.

## Test plan
- Basic: `LATENCY=1`; drive a=3,b=4 then a=200,b=100; model res=7 then 44; `done_i` → `checked_o=2`, `err_cnt_o=0`, `pass_o=1` at D+2.
- Wrap: a=255,b=1 with res=0 → no error. res=1 → `err_cnt_o=1`, `fail_o=1`, `first_exp_o=0`, `first_got_o=1`, `first_idx_o=0`.
- Latency: `LATENCY=3`, 10 back-to-back random pairs with a correct delayed model, `done_i` with the last pair → `checked_o=10`, `pass_o` at D+4, `busy_o` low from then on.
- First-error hold: errors injected at checks 2 and 5 → `err_cnt_o=2`, `first_idx_o=2`. Rebuild without the macro → `first_*_o` stay 0.
- Reset mid-run: assert `reset_i` low after 4 of 8 pairs, release, run 3 fresh pairs → `checked_o=3`, no stale compares.
- Saturation: `CNT_W=4`, 20 mismatching pairs → `err_cnt_o=15`, `checked_o` wraps to 4.
